// File: rtl/mor1kx_branch_resolver.sv
// Queues static branch predictions from decode and checks them against the flag resolved in execute.
// Latency: a resolve in cycle N gives mispredict_o/correct_o in cycle N+1. Optional stats via MOR1KX_BRANCH_STATS_EN.
// Backpressure: pred_ready_o drops when full; a push is still taken while full if the head resolves correctly that cycle.
module mor1kx_branch_resolver #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int DEPTH                = 2,
    parameter int STAT_WIDTH           = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pred_valid_i,
    input  logic                            pred_flag_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pred_target_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pred_fallthru_i,
    output logic                            pred_ready_o,
    input  logic                            res_valid_i,
    input  logic                            flag_i,
    input  logic                            pipeline_flush_i,
    output logic                            mispredict_o,
    output logic                            correct_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
    output logic [$clog2(DEPTH):0]          pending_o,
    output logic                            underflow_o,
    output logic [STAT_WIDTH-1:0]           stat_branches_o,
    output logic [STAT_WIDTH-1:0]           stat_mispred_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic                            flag;
        logic [OPTION_OPERAND_WIDTH-1:0] target;
        logic [OPTION_OPERAND_WIDTH-1:0] fallthru;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    entry_t      push_entry;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        mis_now;
    logic        push;
    logic        underflow_set;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pred_ready_o = !full;
    assign pending_o    = wr_ptr - rd_ptr;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign push_entry = '{flag: pred_flag_i, target: pred_target_i, fallthru: pred_fallthru_i};

    // Flush wins over everything; a mispredicting resolve makes any same-cycle push wrong-path.
    assign pop           = res_valid_i && !empty && !pipeline_flush_i;
    assign mis_now       = pop && (head.flag != flag_i);
    assign push          = pred_valid_i && (!full || pop) && !pipeline_flush_i && !mis_now;
    assign underflow_set = res_valid_i && empty && !pipeline_flush_i;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (pipeline_flush_i || mis_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_o  <= 1'b0;
            correct_o     <= 1'b0;
            redirect_pc_o <= '0;
            underflow_o   <= 1'b0;
        end else begin
            mispredict_o <= mis_now;
            correct_o    <= pop && !mis_now;
            if (mis_now) begin
                redirect_pc_o <= flag_i ? head.target : head.fallthru;
            end
            if (underflow_set) begin
                underflow_o <= 1'b1;
            end
        end
    end

`ifdef MOR1KX_BRANCH_STATS_EN
    logic [STAT_WIDTH-1:0] stat_branches_q;
    logic [STAT_WIDTH-1:0] stat_mispred_q;

    // Counters survive flushes; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (pop) begin
                stat_branches_q <= stat_branches_q + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (mis_now) begin
                stat_mispred_q <= stat_mispred_q + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stat_branches_o = stat_branches_q;
    assign stat_mispred_o  = stat_mispred_q;
`else
    assign stat_branches_o = '0;
    assign stat_mispred_o  = '0;
`endif

    a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(mispredict_o && correct_o));

    a_pending_bound: assert property (@(posedge clk) disable iff (!rst_n)
        pending_o <= DEPTH[AW:0]);

endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// Directed bench for mor1kx_branch_resolver: queue-level reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_mor1kx_branch_resolver;

    localparam int W     = 32;
    localparam int DEPTH = 2;
    localparam int SW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pred_valid_i;
    logic          pred_flag_i;
    logic [W-1:0]  pred_target_i;
    logic [W-1:0]  pred_fallthru_i;
    logic          pred_ready_o;
    logic          res_valid_i;
    logic          flag_i;
    logic          pipeline_flush_i;
    logic          mispredict_o;
    logic          correct_o;
    logic [W-1:0]  redirect_pc_o;
    logic [1:0]    pending_o;
    logic          underflow_o;
    logic [SW-1:0] stat_branches_o;
    logic [SW-1:0] stat_mispred_o;

    int n_total = 0;
    int n_pass  = 0;

    mor1kx_branch_resolver #(
        .OPTION_OPERAND_WIDTH(W),
        .DEPTH(DEPTH),
        .STAT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pred_valid_i(pred_valid_i),
        .pred_flag_i(pred_flag_i),
        .pred_target_i(pred_target_i),
        .pred_fallthru_i(pred_fallthru_i),
        .pred_ready_o(pred_ready_o),
        .res_valid_i(res_valid_i),
        .flag_i(flag_i),
        .pipeline_flush_i(pipeline_flush_i),
        .mispredict_o(mispredict_o),
        .correct_o(correct_o),
        .redirect_pc_o(redirect_pc_o),
        .pending_o(pending_o),
        .underflow_o(underflow_o),
        .stat_branches_o(stat_branches_o),
        .stat_mispred_o(stat_mispred_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: an ordered list of outstanding predictions.
    typedef struct {
        logic         f;
        logic [W-1:0] t;
        logic [W-1:0] ft;
    } ent_t;

    ent_t         q[$];
    ent_t         e;
    logic         exp_mis   = 1'b0;
    logic         exp_cor   = 1'b0;
    logic [W-1:0] exp_redir = '0;
    logic         exp_under = 1'b0;
    logic [SW-1:0] exp_br   = '0;
    logic [SW-1:0] exp_mp   = '0;
    logic         can_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_mis   = 1'b0;
            exp_cor   = 1'b0;
            exp_redir = '0;
            exp_under = 1'b0;
            exp_br    = '0;
            exp_mp    = '0;
        end else begin
            exp_mis = 1'b0;
            exp_cor = 1'b0;
            if (pipeline_flush_i) begin
                q.delete();
            end else if (res_valid_i && q.size() == 0) begin
                exp_under = 1'b1;
                if (pred_valid_i) q.push_back('{pred_flag_i, pred_target_i, pred_fallthru_i});
            end else begin
                can_push = pred_valid_i && (q.size() < DEPTH || res_valid_i);
                if (res_valid_i) begin
                    e = q.pop_front();
                    exp_br = exp_br + 1;
                    if (e.f == flag_i) begin
                        exp_cor = 1'b1;
                        if (can_push) q.push_back('{pred_flag_i, pred_target_i, pred_fallthru_i});
                    end else begin
                        exp_mis   = 1'b1;
                        exp_mp    = exp_mp + 1;
                        exp_redir = flag_i ? e.t : e.ft;
                        q.delete();
                    end
                end else if (can_push) begin
                    q.push_back('{pred_flag_i, pred_target_i, pred_fallthru_i});
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_ready", pred_ready_o, (q.size() < DEPTH) ? 1 : 0);
        chk("m_pending", pending_o, q.size());
        chk("m_mispredict", mispredict_o, exp_mis);
        chk("m_correct", correct_o, exp_cor);
        if (exp_mis) chk("m_redirect", redirect_pc_o, exp_redir);
        chk("m_underflow", underflow_o, exp_under);
`ifdef MOR1KX_BRANCH_STATS_EN
        chk("m_stat_br", stat_branches_o, exp_br);
        chk("m_stat_mp", stat_mispred_o, exp_mp);
`else
        chk("m_stat_br", stat_branches_o, 0);
        chk("m_stat_mp", stat_mispred_o, 0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic pf, input logic [W-1:0] tg,
                         input logic [W-1:0] ft, input logic rv, input logic fl,
                         input logic fs);
        pred_valid_i     = pv;
        pred_flag_i      = pf;
        pred_target_i    = tg;
        pred_fallthru_i  = ft;
        res_valid_i      = rv;
        flag_i           = fl;
        pipeline_flush_i = fs;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        chk("rst_pending", pending_o, 0);
        chk("rst_ready", pred_ready_o, 1);
        chk("rst_mis", mispredict_o, 0);
        chk("rst_redirect", redirect_pc_o, 0);
        rst_n = 1'b1;
        step();

        // Correct prediction
        drive(1, 1, 32'h100, 32'h208, 0, 0, 0); step();
        drive(0, 0, '0, '0, 1, 1, 0); step();
        chk("ok_correct", correct_o, 1);
        chk("ok_mis", mispredict_o, 0);
        chk("ok_pending", pending_o, 0);
        idle(); step();
        chk("ok_pulse_len", correct_o, 0);

        // Mispredict, actually taken
        drive(1, 0, 32'h300, 32'h40C, 0, 0, 0); step();
        drive(0, 0, '0, '0, 1, 1, 0); step();
        chk("mt_mis", mispredict_o, 1);
        chk("mt_redirect", redirect_pc_o, 32'h300);
        idle(); step();
        chk("mt_hold", redirect_pc_o, 32'h300);

        // Mispredict, actually not taken
        drive(1, 1, 32'h500, 32'h604, 0, 0, 0); step();
        drive(0, 0, '0, '0, 1, 0, 0); step();
        chk("mn_redirect", redirect_pc_o, 32'h604);
        idle(); step();

        // Full queue, held push, then squash
        drive(1, 1, 32'h10, 32'h14, 0, 0, 0); step();
        drive(1, 0, 32'h20, 32'h24, 0, 0, 0); step();
        chk("full_ready", pred_ready_o, 0);
        chk("full_pending", pending_o, 2);
        drive(1, 1, 32'h30, 32'h34, 0, 0, 0); step();
        chk("held_pending", pending_o, 2);
        drive(0, 0, '0, '0, 1, 0, 0); step();
        chk("sq_mis", mispredict_o, 1);
        chk("sq_redirect", redirect_pc_o, 32'h14);
        chk("sq_pending", pending_o, 0);
        chk("sq_ready", pred_ready_o, 1);
        idle(); step();

        // Full queue, push with correct resolve in the same cycle
        drive(1, 1, 32'h50, 32'h54, 0, 0, 0); step();
        drive(1, 0, 32'h60, 32'h64, 0, 0, 0); step();
        drive(1, 1, 32'h70, 32'h74, 1, 1, 0); step();
        chk("pr_correct", correct_o, 1);
        chk("pr_pending", pending_o, 2);
        chk("pr_ready", pred_ready_o, 0);
        drive(0, 0, '0, '0, 1, 0, 0); step();
        chk("pr_b_correct", correct_o, 1);
        chk("pr_b_pending", pending_o, 1);
        drive(0, 0, '0, '0, 1, 1, 0); step();
        chk("pr_c_correct", correct_o, 1);
        chk("pr_c_pending", pending_o, 0);
        idle(); step();

        // Flush beats a same-cycle resolve and push
        drive(1, 1, 32'h80, 32'h84, 0, 0, 0); step();
        chk("fl_pending1", pending_o, 1);
        drive(1, 0, 32'h90, 32'h94, 1, 0, 1); step();
        chk("fl_mis", mispredict_o, 0);
        chk("fl_cor", correct_o, 0);
        chk("fl_pending", pending_o, 0);
        chk("fl_under", underflow_o, 0);
        idle(); step();
        chk("fl_mis2", mispredict_o, 0);

        // Resolve on empty queue, same-cycle push must not bypass
        drive(1, 1, 32'hA0, 32'hA4, 1, 1, 0); step();
        chk("uf_under", underflow_o, 1);
        chk("uf_cor", correct_o, 0);
        chk("uf_pending", pending_o, 1);
        idle(); step();
        chk("uf_sticky", underflow_o, 1);
        drive(0, 0, '0, '0, 1, 1, 0); step();
        chk("uf_drain", correct_o, 1);
        chk("uf_sticky2", underflow_o, 1);
        idle(); step();

        // Statistics: 5 resolves, 2 mispredicts after a clean reset
        rst_n = 1'b0; step();
        chk("rs_under", underflow_o, 0);
        rst_n = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'h1000 + i * 16, 32'h1004 + i * 16, 0, 0, 0); step();
            drive(0, 0, '0, '0, 1, (i == 1 || i == 3) ? 1'b0 : 1'b1, 0); step();
        end
        idle(); step();
`ifdef MOR1KX_BRANCH_STATS_EN
        chk("st_branches", stat_branches_o, 5);
        chk("st_mispred", stat_mispred_o, 2);
`else
        chk("st_branches", stat_branches_o, 0);
        chk("st_mispred", stat_mispred_o, 0);
`endif

        // Reset mid-stream discards the queue and a pending pulse
        drive(1, 1, 32'h2000, 32'h2004, 0, 0, 0); step();
        drive(0, 0, '0, '0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_pending", pending_o, 0);
        chk("mr_mis", mispredict_o, 0);
        chk("mr_stat_br", stat_branches_o, 0);
        chk("mr_stat_mp", stat_mispred_o, 0);
        idle(); step();
        rst_n = 1'b1; step();
        chk("mr_mis2", mispredict_o, 0);
        chk("mr_ready", pred_ready_o, 1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
